// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states, and the shadow-stage record mirrored from the pipeline registers.
package pipe_hazard_ctrl_pkg;

   localparam int RN_W    = 5;
   localparam int CNT_W   = 16;
   localparam int NUM_SRC = 2;   // index 0 = rs, 1 = rt

   localparam logic [1:0] FWD_RF   = 2'b00;
   localparam logic [1:0] FWD_EALU = 2'b01;
   localparam logic [1:0] FWD_MALU = 2'b10;
   localparam logic [1:0] FWD_MMEM = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_LU_STALL  = 2'd1,
      ST_EXT_STALL = 2'd2
   } state_e;

   typedef struct packed {
      logic            wreg;
      logic            m2reg;
      logic [RN_W-1:0] rn;
   } shadow_t;

   // r0 is hard-wired zero, so a destination of 0 can never be a hazard.
   function automatic logic rn_match(input logic [RN_W-1:0] rn, input logic [RN_W-1:0] src);
      return (rn != '0) && (rn == src);
   endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Operand forwarding select for one source register: EXE result beats MEM,
// MEM ALU result and MEM load data are distinguished by the load flag.
module pipe_fwd_sel
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] src_i,
   input  logic       use_i,
   input  logic       ewreg_i,
   input  logic       em2reg_i,
   input  logic [4:0] ern_i,
   input  logic       mwreg_i,
   input  logic       mm2reg_i,
   input  logic [4:0] mrn_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (use_i) begin
         if (ewreg_i && !em2reg_i && rn_match(ern_i, src_i))
            sel_o = FWD_EALU;
         else if (mwreg_i && !mm2reg_i && rn_match(mrn_i, src_i))
            sel_o = FWD_MALU;
         else if (mwreg_i && mm2reg_i && rn_match(mrn_i, src_i))
            sel_o = FWD_MMEM;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall and forwarding control for a 5-stage pipeline; tracks the
// E and M stages in shadow registers so detection is purely combinational.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        resetn,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic        users,
   input  logic        usert,
   input  logic        dwreg,
   input  logic        dm2reg,
   input  logic [4:0]  drn,
   input  logic        ext_stall,
   output logic        wpcir,
   output logic [1:0]  fwda,
   output logic [1:0]  fwdb,
   output logic [15:0] stall_cnt,
   output logic [1:0]  fsm_state
);

   shadow_t             e_q, e_d, m_q;
   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                lu;

   logic [NUM_SRC-1:0][RN_W-1:0] src;
   logic [NUM_SRC-1:0]           src_use;
   logic [NUM_SRC-1:0][1:0]      sel;

   assign lu = e_q.wreg && e_q.m2reg &&
               ((users && rn_match(e_q.rn, rs)) || (usert && rn_match(e_q.rn, rt)));
   assign wpcir = ~(lu | ext_stall);

   // A stalled D/E register takes a bubble; rn is held since it is don't-care once wreg=0.
   always_comb begin
      e_d = wpcir ? '{wreg: dwreg, m2reg: dm2reg, rn: drn}
                  : '{wreg: 1'b0, m2reg: 1'b0, rn: e_q.rn};
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!wpcir && cnt_q != '1)
         cnt_d = cnt_q + 16'd1;
   end

   always_comb begin
      state_d = ST_RUN;
      if (ext_stall)
         state_d = ST_EXT_STALL;
      else if (lu)
         state_d = ST_LU_STALL;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         e_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         state_q <= ST_RUN;
      end else begin
         e_q     <= e_d;
         m_q     <= e_q;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign src     = {rt, rs};
   assign src_use = {usert, users};

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
      pipe_fwd_sel u_sel (
         .src_i    (src[g]),
         .use_i    (src_use[g]),
         .ewreg_i  (e_q.wreg),
         .em2reg_i (e_q.m2reg),
         .ern_i    (e_q.rn),
         .mwreg_i  (m_q.wreg),
         .mm2reg_i (m_q.m2reg),
         .mrn_i    (m_q.rn),
         .sel_o    (sel[g])
      );
   end

   assign fwda      = sel[0];
   assign fwdb      = sel[1];
   assign stall_cnt = cnt_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench: the driver pushes hand-computed expectations per
// cycle, the monitor pops and compares them on the falling edge.
module tb_pipe_hazard_ctrl;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [4:0]  rs = '0, rt = '0, drn = '0;
   logic        users = 1'b0, usert = 1'b0, dwreg = 1'b0, dm2reg = 1'b0, ext_stall = 1'b0;
   logic        wpcir;
   logic [1:0]  fwda, fwdb, fsm_state;
   logic [15:0] stall_cnt;

   typedef struct packed {
      logic        w;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [15:0] cnt;
      logic [1:0]  st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_no = 0;

   always #5 clock = ~clock;

   pipe_hazard_ctrl dut (
      .clock     (clock),
      .resetn    (resetn),
      .rs        (rs),
      .rt        (rt),
      .users     (users),
      .usert     (usert),
      .dwreg     (dwreg),
      .dm2reg    (dm2reg),
      .drn       (drn),
      .ext_stall (ext_stall),
      .wpcir     (wpcir),
      .fwda      (fwda),
      .fwdb      (fwdb),
      .stall_cnt (stall_cnt),
      .fsm_state (fsm_state)
   );

   // Monitor: every pushed vector is compared in the same cycle it was driven.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         exp_t a;
         e = exp_q.pop_front();
         a = '{w: wpcir, fa: fwda, fb: fwdb, cnt: stall_cnt, st: fsm_state};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL vec%0d: got wpcir=%b fwda=%b fwdb=%b cnt=%h st=%0d, want wpcir=%b fwda=%b fwdb=%b cnt=%h st=%0d",
                     vec_no, a.w, a.fa, a.fb, a.cnt, a.st, e.w, e.fa, e.fb, e.cnt, e.st);
         end
         vec_no++;
      end
   end

   task automatic step(input logic rst_n, input logic [4:0] a, input logic [4:0] b,
                       input logic ua, input logic ub, input logic dw, input logic dm,
                       input logic [4:0] dn, input logic ex,
                       input logic ew, input logic [1:0] efa, input logic [1:0] efb,
                       input logic [15:0] ecnt, input logic [1:0] est);
      @(posedge clock);
      #1;
      resetn = rst_n; rs = a; rt = b; users = ua; usert = ub;
      dwreg = dw; dm2reg = dm; drn = dn; ext_stall = ex;
      exp_q.push_back('{w: ew, fa: efa, fb: efb, cnt: ecnt, st: est});
   endtask

   initial begin
      //    rst rs  rt  us ut dw dm drn ex | w  fa fb cnt st
      step(0, 0,  0,  0, 0, 0, 0, 0,  0,   1, 0, 0, 0, 0);   // in reset
      // load-use: lw r3 ; add r4,r3,r5
      step(1, 1,  0,  1, 0, 1, 1, 3,  0,   1, 0, 0, 0, 0);
      step(1, 3,  5,  1, 1, 1, 0, 4,  0,   0, 0, 0, 0, 0);
      step(1, 3,  5,  1, 1, 1, 0, 4,  0,   1, 3, 0, 1, 1);
      // ALU back-to-back and one-apart forwarding
      step(1, 6,  7,  1, 1, 1, 0, 2,  0,   1, 0, 0, 1, 0);
      step(1, 4,  2,  1, 1, 1, 0, 8,  0,   1, 2, 1, 1, 0);
      step(1, 2,  2,  0, 1, 0, 0, 0,  0,   1, 0, 2, 1, 0);
      // r0 destination never forwards or stalls
      step(1, 0,  0,  1, 1, 1, 1, 0,  0,   1, 0, 0, 1, 0);
      step(1, 0,  0,  1, 1, 0, 0, 0,  0,   1, 0, 0, 1, 0);
      step(1, 0,  0,  1, 1, 0, 0, 0,  0,   1, 0, 0, 1, 0);
      // ext_stall for 5 cycles overlapping a load-use on r9
      step(1, 0,  0,  0, 0, 1, 1, 9,  0,   1, 0, 0, 1, 0);
      step(1, 9,  0,  1, 0, 1, 0, 10, 1,   0, 0, 0, 1, 0);
      step(1, 9,  0,  1, 0, 1, 0, 10, 1,   0, 3, 0, 2, 2);
      step(1, 9,  0,  1, 0, 1, 0, 10, 1,   0, 0, 0, 3, 2);
      step(1, 9,  0,  1, 0, 1, 0, 10, 1,   0, 0, 0, 4, 2);
      step(1, 9,  0,  1, 0, 1, 0, 10, 1,   0, 0, 0, 5, 2);
      step(1, 9,  0,  1, 0, 1, 0, 10, 0,   1, 0, 0, 6, 2);
      step(1, 0,  0,  0, 0, 0, 0, 0,  0,   1, 0, 0, 6, 0);
      // reset pulsed while in LU_STALL
      step(1, 0,  0,  0, 0, 1, 1, 11, 0,   1, 0, 0, 6, 0);
      step(1, 11, 0,  1, 0, 1, 0, 12, 0,   0, 0, 0, 6, 0);
      step(0, 11, 0,  1, 0, 1, 0, 12, 0,   1, 0, 0, 0, 0);
      step(1, 0,  0,  0, 0, 0, 0, 0,  0,   1, 0, 0, 0, 0);
      // counter saturation under a long external stall
      for (int i = 0; i < 70000; i++) begin
         logic [15:0] ec;
         ec = (i > 65535) ? 16'hFFFF : 16'(i);
         step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, ec, (i == 0) ? 2'd0 : 2'd2);
      end
      step(1, 0,  0,  0, 0, 0, 0, 0,  0,   1, 0, 0, 16'hFFFF, 2);

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
